// File: rtl/mac_reg_master_if.sv
// Avalon-MM-style register bus used for both the host slave port and the MAC control port.
interface mac_reg_master_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] writedata;
    logic              write;
    logic              read;
    logic [DATA_W-1:0] readdata;
    logic              waitrequest;

    modport master (
        output address, writedata, write, read,
        input  readdata, waitrequest
    );

    modport slave (
        input  address, writedata, write, read,
        output readdata, waitrequest
    );
endinterface

// File: rtl/mac_reg_master.sv
// Register-bus master for the MAC control port: serves the reset/config sequencer until
// rst_finish, then the host; waitrequest timeout with a sticky error flag.
//
// state  | meaning
// IDLE   | waiting for a request from the selected source
// ISSUE  | strobe on the MAC port, waiting for waitrequest low or timeout
// DONE   | one-cycle completion: return read data, host waitrequest low
// GAP    | GAP_CYCLES idle cycles so the requester can retire/advance its request
module mac_reg_master #(
    parameter int ADDR_W         = 8,
    parameter int DATA_W         = 32,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rst_addr,
    input  logic [DATA_W-1:0] rst_writedata,
    input  logic              rst_wr,
    input  logic              rst_rd,
    output logic [DATA_W-1:0] rst_readdata,
    output logic              reg_busy,
    input  logic              rst_finish,
    mac_reg_master_if.slave   host,
    mac_reg_master_if.master  mac,
    output logic              timeout_err,
    input  logic              timeout_clr
);

    localparam int          GAP_W     = $clog2(GAP_CYCLES + 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);
    localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [DATA_W-1:0] TMO_DATA = DATA_W'(32'hDEADBEEF);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DONE,
        S_GAP
    } state_t;

    state_t            state_q, state_d;
    logic              src_host_q, src_host_d;
    logic              is_wr_q, is_wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              mac_write_q, mac_write_d;
    logic              mac_read_q, mac_read_d;
    logic [15:0]       tmo_cnt_q, tmo_cnt_d;
    logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
    logic [DATA_W-1:0] rst_readdata_q, rst_readdata_d;
    logic [DATA_W-1:0] host_readdata_q, host_readdata_d;
    logic              timeout_err_q, timeout_err_d;

    logic              req_wr, req_rd;
    logic              finish_access;
    logic              timeout_set;
    logic [DATA_W-1:0] rd_val;

    // Only the side picked by rst_finish is looked at; write wins over read.
    assign req_wr = rst_finish ? host.write : rst_wr;
    assign req_rd = rst_finish ? host.read  : rst_rd;
    // An ISSUE exit with waitrequest still high can only be the timeout abort.
    assign rd_val = mac.waitrequest ? TMO_DATA : mac.readdata;

    always_comb begin
        state_d         = state_q;
        src_host_d      = src_host_q;
        is_wr_d         = is_wr_q;
        addr_d          = addr_q;
        wdata_d         = wdata_q;
        mac_write_d     = mac_write_q;
        mac_read_d      = mac_read_q;
        tmo_cnt_d       = tmo_cnt_q;
        gap_cnt_d       = gap_cnt_q;
        rst_readdata_d  = rst_readdata_q;
        host_readdata_d = host_readdata_q;
        finish_access   = 1'b0;
        timeout_set     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_wr || req_rd) begin
                    src_host_d  = rst_finish;
                    is_wr_d     = req_wr;
                    addr_d      = rst_finish ? host.address   : rst_addr;
                    wdata_d     = rst_finish ? host.writedata : rst_writedata;
                    mac_write_d = req_wr;
                    mac_read_d  = ~req_wr;
                    tmo_cnt_d   = '0;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!mac.waitrequest) begin
                    finish_access = 1'b1;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    finish_access = 1'b1;
                    timeout_set   = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 16'd1;
                end
            end
            S_DONE: begin
                gap_cnt_d = GAP_LOAD;
                state_d   = S_GAP;
            end
            S_GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (finish_access) begin
            state_d     = S_DONE;
            mac_write_d = 1'b0;
            mac_read_d  = 1'b0;
            if (!is_wr_q) begin
                if (src_host_q) begin
                    host_readdata_d = rd_val;
                end else begin
                    rst_readdata_d = rd_val;
                end
            end
        end

        if (timeout_set) begin
            timeout_err_d = 1'b1;
        end else if (timeout_clr) begin
            timeout_err_d = 1'b0;
        end else begin
            timeout_err_d = timeout_err_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            src_host_q      <= 1'b0;
            is_wr_q         <= 1'b0;
            addr_q          <= '0;
            wdata_q         <= '0;
            mac_write_q     <= 1'b0;
            mac_read_q      <= 1'b0;
            tmo_cnt_q       <= '0;
            gap_cnt_q       <= '0;
            rst_readdata_q  <= '0;
            host_readdata_q <= '0;
            timeout_err_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            src_host_q      <= src_host_d;
            is_wr_q         <= is_wr_d;
            addr_q          <= addr_d;
            wdata_q         <= wdata_d;
            mac_write_q     <= mac_write_d;
            mac_read_q      <= mac_read_d;
            tmo_cnt_q       <= tmo_cnt_d;
            gap_cnt_q       <= gap_cnt_d;
            rst_readdata_q  <= rst_readdata_d;
            host_readdata_q <= host_readdata_d;
            timeout_err_q   <= timeout_err_d;
        end
    end

    assign mac.address      = addr_q;
    assign mac.writedata    = wdata_q;
    assign mac.write        = mac_write_q;
    assign mac.read         = mac_read_q;
    assign rst_readdata     = rst_readdata_q;
    assign host.readdata    = host_readdata_q;
    assign host.waitrequest = ~((state_q == S_DONE) && src_host_q);
    assign reg_busy         = ((state_q == S_ISSUE) || (state_q == S_DONE)) && !src_host_q;
    assign timeout_err      = timeout_err_q;

endmodule

// File: tb/tb_mac_reg_master.sv
// Directed bench for mac_reg_master: sequencer burst, MAC stalls, reads, host access,
// timeout abort/clear and mid-access reset.
module tb_mac_reg_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rst_addr = '0;
    logic [31:0] rst_writedata = '0;
    logic        rst_wr = 1'b0;
    logic        rst_rd = 1'b0;
    logic [31:0] rst_readdata;
    logic        reg_busy;
    logic        rst_finish = 1'b0;
    logic        timeout_err;
    logic        timeout_clr = 1'b0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    mac_reg_master_if #(.ADDR_W(8), .DATA_W(32)) host_if ();
    mac_reg_master_if #(.ADDR_W(8), .DATA_W(32)) mac_if ();

    mac_reg_master #(
        .ADDR_W(8), .DATA_W(32), .GAP_CYCLES(2), .TIMEOUT_CYCLES(1024)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .rst_addr(rst_addr), .rst_writedata(rst_writedata),
        .rst_wr(rst_wr), .rst_rd(rst_rd),
        .rst_readdata(rst_readdata), .reg_busy(reg_busy),
        .rst_finish(rst_finish),
        .host(host_if.slave), .mac(mac_if.master),
        .timeout_err(timeout_err), .timeout_clr(timeout_clr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    logic [7:0]  b_addr [3];
    logic [31:0] b_data [3];
    int rise [3];
    int n, ws, bs, hwl, cnt;
    logic ok;
    logic [7:0]  seen_a;
    logic [31:0] seen_d;

    initial begin
        b_addr[0] = 8'd3; b_data[0] = 32'h0615_0910;
        b_addr[1] = 8'd4; b_data[1] = 32'h0000_2019;
        b_addr[2] = 8'd9; b_data[2] = 32'h0000_0500;
        host_if.address = '0; host_if.writedata = '0;
        host_if.write = 1'b0; host_if.read = 1'b0;
        mac_if.readdata = '0; mac_if.waitrequest = 1'b0;

        // reset values
        tick(); tick();
        chk("rst_mac_write", {31'd0, mac_if.write}, 32'd0);
        chk("rst_mac_read", {31'd0, mac_if.read}, 32'd0);
        chk("rst_reg_busy", {31'd0, reg_busy}, 32'd0);
        chk("rst_host_wait", {31'd0, host_if.waitrequest}, 32'd1);
        chk("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
        chk("rst_readdata", rst_readdata, 32'd0);
        chk("rst_host_readdata", host_if.readdata, 32'd0);
        chk("rst_mac_address", {24'd0, mac_if.address}, 32'd0);
        rst_n = 1'b1;
        tick();

        // 1: sequencer burst with level-held rst_wr
        rst_wr = 1'b1;
        for (int k = 0; k < 3; k++) begin
            rst_addr = b_addr[k];
            rst_writedata = b_data[k];
            n = 0;
            while (!mac_if.write && n < 20) begin tick(); n++; end
            chk("t1_strobe_seen", {31'd0, mac_if.write}, 32'd1);
            rise[k] = cyc;
            chk("t1_addr", {24'd0, mac_if.address}, {24'd0, b_addr[k]});
            chk("t1_data", mac_if.writedata, b_data[k]);
            ws = 0; bs = 0; n = 0;
            while ((mac_if.write || reg_busy) && n < 40) begin
                if (mac_if.write) ws++;
                if (reg_busy) bs++;
                tick(); n++;
            end
            chk("t1_strobe_len", ws, 32'd1);
            chk("t1_busy_len", bs, 32'd2);
            if (k == 2) rst_wr = 1'b0;
        end
        chk("t1_spacing_a", rise[1] - rise[0], 32'd5);
        chk("t1_spacing_b", rise[2] - rise[1], 32'd5);
        tick(); tick(); tick(); tick();

        // 2: MAC stalls with waitrequest for 4 sampled cycles
        mac_if.waitrequest = 1'b1;
        rst_addr = 8'd10; rst_writedata = 32'hA5A5_0010; rst_wr = 1'b1;
        n = 0;
        while (!mac_if.write && n < 20) begin tick(); n++; end
        ws = 0; bs = 0; n = 0; ok = 1'b1;
        while ((mac_if.write || reg_busy) && n < 40) begin
            if (mac_if.write) begin
                ws++;
                if (mac_if.address !== 8'd10 || mac_if.writedata !== 32'hA5A5_0010) ok = 1'b0;
                if (ws == 5) mac_if.waitrequest = 1'b0;
            end
            if (reg_busy) bs++;
            tick(); n++;
        end
        rst_wr = 1'b0;
        chk("t2_strobe_len", ws, 32'd5);
        chk("t2_busy_len", bs, 32'd6);
        chk("t2_addr_data_stable", {31'd0, ok}, 32'd1);
        mac_if.waitrequest = 1'b0;
        tick(); tick(); tick(); tick();

        // 3: sequencer read of address 8
        mac_if.readdata = 32'h1234_5678;
        rst_addr = 8'd8; rst_rd = 1'b1;
        n = 0; ok = 1'b1;
        while (!mac_if.read && n < 20) begin
            if (mac_if.write) ok = 1'b0;
            tick(); n++;
        end
        chk("t3_read_seen", {31'd0, mac_if.read}, 32'd1);
        chk("t3_read_addr", {24'd0, mac_if.address}, 32'd8);
        if (mac_if.write) ok = 1'b0;
        tick();
        chk("t3_done_readdata", rst_readdata, 32'h1234_5678);
        chk("t3_done_busy", {31'd0, reg_busy}, 32'd1);
        chk("t3_done_strobe_low", {31'd0, mac_if.read}, 32'd0);
        if (mac_if.write) ok = 1'b0;
        tick();
        rst_rd = 1'b0;
        mac_if.readdata = 32'h0BAD_0BAD;
        for (int i = 0; i < 5; i++) begin
            if (mac_if.write) ok = 1'b0;
            tick();
        end
        chk("t3_readdata_held", rst_readdata, 32'h1234_5678);
        chk("t3_no_write", {31'd0, ok}, 32'd1);

        // 4: host write after rst_finish; sequencer request ignored
        rst_finish = 1'b1;
        rst_addr = 8'h77; rst_writedata = 32'h99; rst_wr = 1'b1;
        host_if.address = 8'd2; host_if.writedata = 32'h55; host_if.write = 1'b1;
        ws = 0; bs = 0; hwl = 0;
        seen_a = '0; seen_d = '0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (mac_if.write) begin
                ws++; seen_a = mac_if.address; seen_d = mac_if.writedata;
            end
            if (reg_busy) bs++;
            if (!host_if.waitrequest) begin
                hwl++;
                host_if.write = 1'b0;
            end
        end
        rst_wr = 1'b0;
        chk("t4_write_count", ws, 32'd1);
        chk("t4_addr", {24'd0, seen_a}, 32'd2);
        chk("t4_data", seen_d, 32'h55);
        chk("t4_hwait_low_len", hwl, 32'd1);
        chk("t4_busy_never", bs, 32'd0);

        // 5: stuck MAC, host read times out
        mac_if.waitrequest = 1'b1;
        host_if.address = 8'd5; host_if.read = 1'b1;
        n = 0;
        while (!mac_if.read && n < 20) begin tick(); n++; end
        cnt = 0;
        while (mac_if.read && cnt < 1100) begin cnt++; tick(); end
        host_if.read = 1'b0;
        chk("t5_issue_len", cnt, 32'd1024);
        chk("t5_hwait_low", {31'd0, host_if.waitrequest}, 32'd0);
        chk("t5_host_readdata", host_if.readdata, 32'hDEAD_BEEF);
        chk("t5_err_set", {31'd0, timeout_err}, 32'd1);
        tick(); tick(); tick();
        chk("t5_err_sticky", {31'd0, timeout_err}, 32'd1);
        chk("t5_hwait_back", {31'd0, host_if.waitrequest}, 32'd1);
        timeout_clr = 1'b1;
        tick();
        chk("t5_err_cleared", {31'd0, timeout_err}, 32'd0);
        host_if.read = 1'b1;
        n = 0;
        while (!mac_if.read && n < 20) begin tick(); n++; end
        cnt = 0;
        while (mac_if.read && cnt < 1100) begin
            cnt++;
            if (cnt == 10) chk("t5_err_low_with_clr", {31'd0, timeout_err}, 32'd0);
            tick();
        end
        timeout_clr = 1'b0;
        host_if.read = 1'b0;
        chk("t5_issue_len2", cnt, 32'd1024);
        chk("t5_set_beats_clr", {31'd0, timeout_err}, 32'd1);
        tick(); tick();
        chk("t5_err_sticky2", {31'd0, timeout_err}, 32'd1);
        timeout_clr = 1'b1;
        tick();
        timeout_clr = 1'b0;
        chk("t5_err_cleared2", {31'd0, timeout_err}, 32'd0);
        mac_if.waitrequest = 1'b0;
        tick(); tick(); tick(); tick();

        // 6: reset pulse mid-ISSUE
        rst_finish = 1'b0;
        mac_if.waitrequest = 1'b1;
        rst_addr = 8'h21; rst_writedata = 32'hCAFE_0021; rst_wr = 1'b1;
        n = 0;
        while (!mac_if.write && n < 20) begin tick(); n++; end
        tick(); tick();
        chk("t6_in_issue", {31'd0, mac_if.write}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_write_abort", {31'd0, mac_if.write}, 32'd0);
        chk("t6_busy_abort", {31'd0, reg_busy}, 32'd0);
        chk("t6_hwait_reset", {31'd0, host_if.waitrequest}, 32'd1);
        tick();
        mac_if.waitrequest = 1'b0;
        rst_n = 1'b1;
        n = 0;
        while (!mac_if.write && n < 20) begin tick(); n++; end
        chk("t6_reaccept", {31'd0, mac_if.write}, 32'd1);
        chk("t6_addr", {24'd0, mac_if.address}, 32'h21);
        chk("t6_data", mac_if.writedata, 32'hCAFE_0021);
        ws = 0; bs = 0; n = 0;
        while ((mac_if.write || reg_busy) && n < 40) begin
            if (mac_if.write) ws++;
            if (reg_busy) bs++;
            tick(); n++;
        end
        rst_wr = 1'b0;
        chk("t6_strobe_len", ws, 32'd1);
        chk("t6_busy_len", bs, 32'd2);
        tick(); tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
